// File: rtl/seq_detector_prog.sv
// seq_detector_prog
// Programmable serial-pattern detector. A 1..MAX_LEN bit pattern is compared
// against the most recent valid bits of a serial stream. A hit is reported
// combinationally (detected_o), registered one cycle later (detected_q_o), and
// counted by a saturating match counter. Overlapping or non-overlapping
// matching is selected every cycle by overlap_i.

module seq_detector_prog #(
    parameter int                         MAX_LEN         = 16,
    parameter int                         LEN_W           = $clog2(MAX_LEN) + 1,
    parameter int                         CNT_W           = 8,
    parameter logic [MAX_LEN-1:0]         DEFAULT_PATTERN = MAX_LEN'(16'h0056),
    parameter int                         DEFAULT_LEN     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_i,
    input  logic               in_valid_i,
    input  logic               overlap_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               count_clr_i,
    output logic               detected_o,
    output logic               detected_q_o,
    output logic [CNT_W-1:0]   match_count_o,
    output logic               armed_o,
    output logic               cfg_err_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam logic [LEN_W-1:0] LEN_MAX_C  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_DEF_C  = LEN_W'(DEFAULT_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT_C  = {CNT_W{1'b1}};

    // Configuration and control state
    state_e             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               cfg_err_q;

    // Stream history. Only the newest MAX_LEN-1 bits are kept: together with
    // the bit arriving this cycle they form the full comparison window, so an
    // older bit could never take part in a match.
    logic [MAX_LEN-2:0] hist_q;
    logic [MAX_LEN-2:0] hist_d;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;

    // Outputs held in flops
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               det_q;

    // Decoded control
    logic               take_bit;
    logic               cfg_legal;
    logic               legal_load;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] window;
    logic               pat_hit;
    logic               fill_ok;
    logic               detected;

    // A data bit is consumed only when it is valid and not displaced by a
    // configuration load in the same cycle.
    assign take_bit   = in_valid_i & ~cfg_load_i;
    assign cfg_legal  = (cfg_len_i != '0) && (cfg_len_i <= LEN_MAX_C);
    assign legal_load = cfg_load_i & cfg_legal;

    // Per-bit mask selecting the low len_q bits of the window and pattern;
    // pattern bits above len-1 never influence a match.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_q);
        end
    endgenerate

    // Window: past valid bits with the current bit appended as the newest.
    assign window  = {hist_q, in_i};
    assign pat_hit = (((window ^ pat_q) & len_mask) == '0);

    // Enough bits since the last clear to form a full pattern including the
    // current one. len_q is never zero, so len_q-1 cannot underflow.
    assign fill_ok = (fill_q >= (len_q - LEN_W'(1)));

    // Mealy hit: zero latency from the final pattern bit.
    assign detected = (state_q == ARMED) & take_bit & fill_ok & pat_hit;

    // Next history / fill count: cleared by a legal load, advanced by a
    // consumed bit, and fill restarts after a hit in non-overlapping mode.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (legal_load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (take_bit) begin
            hist_d = window[MAX_LEN-2:0];
            if (detected && !overlap_i) begin
                fill_d = '0;
            end else if (fill_q != LEN_MAX_C) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    // Next match count: clear wins but still counts a coincident hit;
    // otherwise a hit increments and the count saturates without wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr_i) begin
            cnt_d = detected ? CNT_W'(1) : '0;
        end else if (detected && (cnt_q != CNT_SAT_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Configuration FSM: legal loads arm the detector with the new pattern,
    // illegal loads disarm it and flag the error while keeping old pattern/len.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARMED;
            pat_q     <= DEFAULT_PATTERN;
            len_q     <= LEN_DEF_C;
            cfg_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (legal_load) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (cfg_load_i && !cfg_legal) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (cfg_load_i) begin
                if (cfg_legal) begin
                    pat_q     <= cfg_pattern_i;
                    len_q     <= cfg_len_i;
                    cfg_err_q <= 1'b0;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    // Stream history and fill counter; reset discards any partial match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Registered hit flag and saturating match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            det_q <= detected;
            cnt_q <= cnt_d;
        end
    end

    assign detected_o    = detected;
    assign detected_q_o  = det_q;
    assign match_count_o = cnt_q;
    assign armed_o       = (state_q == ARMED);
    assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Testbench for seq_detector_prog: directed scenarios followed by random
// traffic, each step compared against a queue-based model of the stream.

module tb_seq_detector_prog;

    localparam int ML   = 16;
    localparam int LW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_b;
    logic          in_valid;
    logic          overlap;
    logic          cfg_load;
    logic [ML-1:0] cfg_pattern;
    logic [LW-1:0] cfg_len;
    logic          count_clr;
    logic          detected;
    logic          detected_q;
    logic [CW-1:0] match_count;
    logic          armed;
    logic          cfg_err;

    seq_detector_prog #(
        .MAX_LEN(ML),
        .LEN_W  (LW),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_i         (in_b),
        .in_valid_i   (in_valid),
        .overlap_i    (overlap),
        .cfg_load_i   (cfg_load),
        .cfg_pattern_i(cfg_pattern),
        .cfg_len_i    (cfg_len),
        .count_clr_i  (count_clr),
        .detected_o   (detected),
        .detected_q_o (detected_q),
        .match_count_o(match_count),
        .armed_o      (armed),
        .cfg_err_o    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the valid bits received since the last clear, oldest first.
    bit            q[$];
    logic [ML-1:0] m_pat;
    int            m_len;
    logic          m_armed;
    logic          m_err;
    int            m_cnt;
    logic          m_detq;
    logic          last_det;
    logic [31:0]   hit_mask;
    logic [6:0]    def_s;
    logic [15:0]   big_s;
    int            nstep = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // The newest len received bits, current bit last, must equal pattern bits
    // len-1 .. 0 in arrival order.
    function automatic logic m_match(input logic b);
        int n;
        n = q.size();
        if (n + 1 < m_len) return 1'b0;
        if (b !== m_pat[0]) return 1'b0;
        for (int k = 1; k < m_len; k++) begin
            if (q[n-k] !== m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pat   = 16'h0056;
        m_len   = 7;
        m_armed = 1'b1;
        m_err   = 1'b0;
        m_cnt   = 0;
        m_detq  = 1'b0;
    endtask

    task automatic step(input logic b, input logic v, input logic o, input logic ld,
                        input logic [ML-1:0] p, input logic [LW-1:0] l, input logic clr);
        logic exp_det;
        in_b        = b;
        in_valid    = v;
        overlap     = o;
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_len     = l;
        count_clr   = clr;
        #2;
        exp_det = m_armed && v && !ld && m_match(b);
        check("detected", {31'd0, detected}, {31'd0, exp_det});
        last_det = detected;
        @(posedge clk);
        if (ld) begin
            if (l != 0 && int'(l) <= ML) begin
                m_pat   = p;
                m_len   = int'(l);
                q.delete();
                m_armed = 1'b1;
                m_err   = 1'b0;
            end else begin
                m_armed = 1'b0;
                m_err   = 1'b1;
            end
        end else if (v) begin
            q.push_back(b);
            if (exp_det && !o) q.delete();
            if (q.size() > 40) void'(q.pop_front());
        end
        if (clr) m_cnt = exp_det ? 1 : 0;
        else if (exp_det && m_cnt < CMAX) m_cnt++;
        m_detq = exp_det;
        #1;
        check("detected_q", {31'd0, detected_q}, {31'd0, m_detq});
        check("match_count", {28'd0, match_count}, 32'(m_cnt));
        check("armed", {31'd0, armed}, {31'd0, m_armed});
        check("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
        nstep++;
        $display("step %0d in=%b vld=%b ovl=%b ld=%b len=%0d clr=%b det=%b cnt=%0d armed=%b err=%b",
                 nstep, b, v, o, ld, l, clr, last_det, match_count, armed, cfg_err);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        count_clr = 1'b0;
        rst_n     = 1'b0;
        #2;
        check("rst_armed", {31'd0, armed}, 32'd1);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("rst_count", {28'd0, match_count}, 32'd0);
        check("rst_detected_q", {31'd0, detected_q}, 32'd0);
        check("rst_detected", {31'd0, detected}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset applied and released");
    endtask

    task automatic idle_clr();
        step(1'b0, 1'b0, overlap, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b1; in_b = 1'b0; in_valid = 1'b0; overlap = 1'b1;
        cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; count_clr = 1'b0;
        def_s = 7'b1010110;
        big_s = 16'hA5C3;
        #1;
        do_reset();

        // Default pattern after reset
        hit_mask = '0;
        for (int i = 0; i < 7; i++) begin
            step(def_s[6-i], 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            if (last_det) hit_mask[i] = 1'b1;
        end
        check("default_hits", hit_mask, 32'h40);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        check("default_count", {28'd0, match_count}, 32'd1);

        // Overlapping 101
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFF5, 5'd3, 1'b1);
        hit_mask = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'(i % 2 == 0), 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            if (last_det) hit_mask[i] = 1'b1;
        end
        check("overlap_hits", hit_mask, 32'h14);
        check("overlap_count", {28'd0, match_count}, 32'd2);

        // Non-overlapping 101 on 1,0,1,1,0,1
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 5'd3, 1'b1);
        hit_mask = '0;
        for (int i = 0; i < 6; i++) begin
            logic [5:0] s;
            s = 6'b101101;
            step(s[5-i], 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
            if (last_det) hit_mask[i] = 1'b1;
        end
        check("nonoverlap_hits", hit_mask, 32'h24);
        check("nonoverlap_count", {28'd0, match_count}, 32'd2);

        // Default pattern with gaps in in_valid
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0056, 5'd7, 1'b1);
        hit_mask = '0;
        for (int i = 0; i < 7; i++) begin
            step(def_s[6-i], 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            if (last_det) hit_mask[i] = 1'b1;
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        end
        check("gated_hits", hit_mask, 32'h40);
        check("gated_count", {28'd0, match_count}, 32'd1);

        // Reset after five bits discards the partial match
        for (int i = 0; i < 5; i++) step(def_s[6-i], 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        do_reset();
        hit_mask = '0;
        for (int i = 0; i < 7; i++) begin
            step(def_s[6-i], 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            if (last_det) hit_mask[i] = 1'b1;
        end
        check("post_reset_hits", hit_mask, 32'h40);
        check("post_reset_count", {28'd0, match_count}, 32'd1);

        // Illegal length disarms
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 5'd0, 1'b1);
        check("illegal_armed", {31'd0, armed}, 32'd0);
        check("illegal_err", {31'd0, cfg_err}, 32'd1);
        hit_mask = '0;
        for (int i = 0; i < 14; i++) begin
            step(def_s[6-(i%7)], 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            if (last_det) hit_mask[i] = 1'b1;
        end
        check("illegal_hits", hit_mask, 32'h0);

        // Full-length pattern
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'hA5C3, 5'd16, 1'b1);
        check("full_armed", {31'd0, armed}, 32'd1);
        check("full_err", {31'd0, cfg_err}, 32'd0);
        hit_mask = '0;
        for (int i = 0; i < 16; i++) begin
            step(big_s[15-i], 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
            if (last_det) hit_mask[i] = 1'b1;
        end
        check("full_hits", hit_mask, 32'h8000);

        // Load on the final matching bit suppresses the hit
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'hA5C3, 5'd16, 1'b1);
        for (int i = 0; i < 15; i++) step(big_s[15-i], 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        step(big_s[0], 1'b1, 1'b1, 1'b1, 16'hA5C3, 5'd16, 1'b0);
        check("load_kill_det", {31'd0, last_det}, 32'd0);
        check("load_kill_count", {28'd0, match_count}, 32'd0);

        // Counter saturation and clear interaction with len 1
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 5'd1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        check("sat_count", {28'd0, match_count}, 32'd15);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
        check("clr_hit_count", {28'd0, match_count}, 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
        check("clr_only_count", {28'd0, match_count}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 1200; n++) begin
            logic          rb, rv, ro, rld, rclr;
            logic [ML-1:0] rp;
            logic [LW-1:0] rl;
            int            sel;
            rb   = 1'($urandom_range(0, 1));
            rv   = ($urandom_range(0, 9) < 8);
            ro   = ((n / 50) % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rld  = ($urandom_range(0, 99) < 3);
            rclr = ($urandom_range(0, 99) < 3);
            rp   = ML'($urandom);
            sel  = $urandom_range(0, 9);
            if (sel == 0)      rl = 5'd0;
            else if (sel == 1) rl = 5'($urandom_range(17, 31));
            else if (sel == 2) rl = 5'($urandom_range(5, 16));
            else               rl = 5'($urandom_range(1, 4));
            if ($urandom_range(0, 299) == 0) do_reset();
            step(rb, rv, ro, rld, rp, rl, rclr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
